median_stream_filter: RTL and testbench
=======================================

Name: median_stream_filter

Overview:
- Streaming sliding-window median filter: one sample accepted per handshake.
- Outputs the median of the last DEPTH accepted samples.
- Generalises the fixed 7-input combinational median finder to:
  - parametrised data width and odd window depth;
  - optional signed compare;
  - valid/ready flow control on both sides.
- Sits between a sample source and downstream processing, e.g. an image/line noise filter.

Parameters:
- WIDTH, 4, sample width in bits (1..16).
- DEPTH, 7, window length; odd, 3..31. Elaboration error if even or out of range.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous window flush.
- in_valid  input  1  sample present.
- in_ready  output  1  filter can accept.
- in_data  input  WIDTH  sample.
- out_valid  output  1  median present.
- out_ready  input  1  downstream accepts.
- median  output  WIDTH  median of current window.
- win_min  output  WIDTH  smallest value in window.
- win_max  output  WIDTH  largest value in window.
- fill  output  $clog2(DEPTH+1)  samples currently held (saturates at DEPTH).

Behaviour:
- Reset (rst=1 at a clock edge):
  - fill=0, out_valid=0, median/win_min/win_max=0.
  - All slots invalid; rst overrides everything else.
- Storage:
  - DEPTH slots kept in sorted order (ascending per SIGNED), each holding a value and an age (0..DEPTH-1).
  - No separate FIFO.
- Handshake:
  - in_ready = !clear && (!out_valid || out_ready); combinational.
  - Accept = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- On accept, all in one cycle:
  - If fill==DEPTH, the slot with age DEPTH-1 is removed.
  - All remaining ages are incremented.
  - in_data is inserted at its sorted position with age 0.
  - Ties: the new sample is placed after existing equal values (stable).
  - fill increments, saturating at DEPTH.
- Output register:
  - Latency 1 cycle: on the edge of an accept that leaves fill==DEPTH, the same edge loads median=sorted[(DEPTH-1)/2], win_min=sorted[0], win_max=sorted[DEPTH-1], and sets out_valid=1.
  - Warm-up: accepts with resulting fill<DEPTH do not raise out_valid; outputs hold their previous values.
  - Transfer with no simultaneous qualifying accept → out_valid=0 next cycle.
  - Transfer and accept in the same cycle → new result loaded, out_valid stays 1 (full throughput, one median per cycle).
  - out_valid=1 && out_ready=0 → outputs held stable and in_ready=0 (backpressure).
- clear (rst=0):
  - fill=0, out_valid=0, all slots invalid next cycle.
  - median/win_min/win_max hold their values.
  - Beats any simultaneous accept; in_ready is forced low while clear=1, so no sample is lost silently.
- fill is combinationally visible and updated on the same edge as the slots.
- Signed mode: compares interpret MSB as sign, e.g. 4'hF (−1) < 4'h0.
- in_valid while in_ready=0: the bench must hold in_data stable. The block does not latch it.

Test Plan:
- Warm-up, WIDTH=4, DEPTH=7, SIGNED=0, out_ready=1:
  - Send 3,1,4,1,5,9,2 → out_valid first asserts exactly 1 cycle after the 7th accept.
  - median=3, win_min=1, win_max=9, fill=7.
  - No out_valid during samples 1–6.
- Sliding, continuing the same stream:
  - Send 6 → median=4 (window 1,4,1,5,9,2,6).
  - Then 5 → median=5, win_min=1, win_max=9.
  - Back-to-back accepts give one result per cycle.
- Backpressure:
  - After the window is full, hold out_ready=0 for 4 cycles with in_valid=1 → in_ready=0 throughout and median held.
  - Release out_ready → the next sample is accepted and the result appears 1 cycle later.
  - No sample dropped or duplicated (check against a reference queue model).
- Duplicates and eviction:
  - Send 15 seven times → median=15, win_min=win_max=15.
  - Then 0 seven times → median is 15 after the 1st–3rd zeros and 0 from the 4th zero onward.
  - Confirms oldest-first eviction with ties.
- Signed mode, SIGNED=1, WIDTH=4, DEPTH=3:
  - Send 4'hF, 4'h2, 4'h8 → median=4'hF (−1), win_min=4'h8, win_max=4'h2.
- Reset/clear mid-stream:
  - Assert clear after 4 samples with in_valid=1 → in_ready=0 that cycle, fill=0 next cycle.
  - 7 new samples are needed before out_valid.
  - Assert rst while out_valid=1 → out_valid=0, median=0, fill=0 the next cycle.

Source files
------------

// File: rtl/median_stream_filter.sv
// rtl/median_stream_filter.sv - sliding-window median filter over a sorted, age-tagged slot array
module median_stream_filter #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 7,
    parameter bit SIGNED = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             median,
    output logic [WIDTH-1:0]             win_min,
    output logic [WIDTH-1:0]             win_max,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int MID = (DEPTH - 1) / 2;
    localparam logic [WIDTH-1:0] FLIP = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    if (DEPTH < 3 || DEPTH > 31 || (DEPTH % 2) == 0) begin : g_bad_depth
        $error("median_stream_filter: DEPTH must be odd and within 3..31");
    end
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("median_stream_filter: WIDTH must be within 1..16");
    end

    // Flipping the MSB turns a two's-complement compare into an unsigned one.
    function automatic logic le(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a ^ FLIP) <= (b ^ FLIP);
    endfunction

    logic [WIDTH-1:0] slot_val [DEPTH];
    logic [CW-1:0]    slot_age [DEPTH];
    logic [CW-1:0]    fill_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] median_q, min_q, max_q;

    logic             full, accept, xfer, seen;
    logic [WIDTH-1:0] vx  [DEPTH+1];
    logic [CW-1:0]    ax  [DEPTH+1];
    logic [WIDTH-1:0] kx  [DEPTH+1];
    logic [CW-1:0]    kax [DEPTH+1];
    logic [WIDTH-1:0] nv  [DEPTH];
    logic [CW-1:0]    na  [DEPTH];
    logic [CW-1:0]    kcnt, pos, nfill;

    assign full      = (fill_q == CW'(DEPTH));
    assign in_ready  = !clear && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid_q && out_ready;
    assign kcnt      = full ? CW'(DEPTH - 1) : fill_q;
    assign nfill     = full ? fill_q : fill_q + CW'(1);
    assign fill      = fill_q;
    assign out_valid = out_valid_q;
    assign median    = median_q;
    assign win_min   = min_q;
    assign win_max   = max_q;

    // kx[i+1] is the i-th survivor after dropping the oldest slot; kx[0] is a pad.
    always_comb begin
        seen = 1'b0;
        pos  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vx[i] = slot_val[i];
            ax[i] = slot_age[i];
        end
        vx[DEPTH] = '0;
        ax[DEPTH] = '0;
        kx[0]     = '0;
        kax[0]    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            seen       = seen | (full && slot_age[i] == CW'(DEPTH - 1));
            kx[i+1]    = seen ? vx[i+1] : vx[i];
            kax[i+1]   = seen ? ax[i+1] : ax[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < kcnt && le(kx[i+1], in_data)) begin
                pos = pos + CW'(1);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < pos) begin
                nv[i] = kx[i+1];
                na[i] = kax[i+1] + CW'(1);
            end else if (CW'(i) == pos) begin
                nv[i] = in_data;
                na[i] = '0;
            end else begin
                nv[i] = kx[i];
                na[i] = kax[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            median_q    <= '0;
            min_q       <= '0;
            max_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_val[i] <= '0;
                slot_age[i] <= '0;
            end
        end else if (clear) begin
            fill_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            slot_val <= nv;
            slot_age <= na;
            fill_q   <= nfill;
            if (nfill == CW'(DEPTH)) begin
                out_valid_q <= 1'b1;
                median_q    <= nv[MID];
                min_q       <= nv[0];
                max_q       <= nv[DEPTH-1];
            end else if (xfer) begin
                out_valid_q <= 1'b0;
            end
        end else if (xfer) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_median_stream_filter.sv
// tb/tb_median_stream_filter.sv - self-checking bench for median_stream_filter
module tb_median_stream_filter;
    localparam int D = 7;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] in_data, median, win_min, win_max;
    logic [2:0] fill;

    logic       s_clear, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [3:0] s_in_data, s_median, s_min, s_max;
    logic [1:0] s_fill;

    median_stream_filter #(.WIDTH(4), .DEPTH(D), .SIGNED(1'b0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .median(median),
        .win_min(win_min), .win_max(win_max), .fill(fill)
    );

    median_stream_filter #(.WIDTH(4), .DEPTH(3), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .median(s_median),
        .win_min(s_min), .win_max(s_max), .fill(s_fill)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    int q[$];
    int m_ov = 0, m_med = 0, m_min = 0, m_max = 0;

    typedef struct {
        logic [3:0] d;
        logic       ov;
        logic       chk;
        int         med;
        int         mn;
        int         mx;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] d, input logic ov, input logic chk,
                                input int med, input int mn, input int mx);
        vec_t v;
        v.d = d; v.ov = ov; v.chk = chk; v.med = med; v.mn = mn; v.mx = mx;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_stats();
        int s[$];
        s = q;
        s.sort();
        m_med = s[(D-1)/2];
        m_min = s[0];
        m_max = s[s.size()-1];
    endtask

    // One clock with the inputs already driven; updates the reference model and compares.
    task automatic step(output logic acc_o);
        logic exp_rdy, acc, xf;
        #1;
        exp_rdy = !clear && (m_ov == 0 || out_ready);
        check("in_ready", int'(in_ready), int'(exp_rdy));
        acc = in_valid && exp_rdy;
        xf  = (m_ov != 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_ov = 0; m_med = 0; m_min = 0; m_max = 0;
        end else if (clear) begin
            q.delete();
            m_ov = 0;
        end else begin
            if (acc) begin
                q.push_back(int'(in_data));
                if (q.size() > D) void'(q.pop_front());
            end
            if (acc && q.size() == D) begin
                m_ov = 1;
                model_stats();
            end else if (xf) begin
                m_ov = 0;
            end
        end
        acc_o = acc;
        check("out_valid", int'(out_valid), m_ov);
        check("fill", int'(fill), q.size());
        check("median", int'(median), m_med);
        check("win_min", int'(win_min), m_min);
        check("win_max", int'(win_max), m_max);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        logic pending;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        s_clear = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset fill", int'(fill), 0);
        check("reset median", int'(median), 0);
        check("reset win_min", int'(win_min), 0);
        check("reset win_max", int'(win_max), 0);
        rst = 1'b0;

        // Warm-up, sliding, then duplicate-heavy eviction, all back to back.
        tbl.push_back(mk(4'd3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd4, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd5, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd9, 0, 0, 0, 0, 0));
        tbl.push_back(mk(4'd2, 1, 1, 3, 1, 9));
        tbl.push_back(mk(4'd6, 1, 1, 4, 1, 9));
        tbl.push_back(mk(4'd5, 1, 1, 5, 1, 9));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(4'd15, 1, 0, 0, 0, 0));
        tbl.push_back(mk(4'd15, 1, 1, 15, 15, 15));
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(4'd0, 1, 1, (k >= 4) ? 0 : 15, 0, (k == 7) ? 0 : 15));

        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = 1'b1;
            in_data  = tbl[i].d;
            step(a);
            check($sformatf("tbl[%0d] out_valid", i), int'(out_valid), int'(tbl[i].ov));
            if (tbl[i].chk) begin
                check($sformatf("tbl[%0d] median", i), int'(median), tbl[i].med);
                check($sformatf("tbl[%0d] win_min", i), int'(win_min), tbl[i].mn);
                check($sformatf("tbl[%0d] win_max", i), int'(win_max), tbl[i].mx);
            end
        end

        // Backpressure: four stalled cycles, then release.
        out_ready = 1'b0;
        in_data   = 4'd7;
        for (int i = 0; i < 4; i++) begin
            step(a);
            check("stall held median", int'(median), 0);
        end
        out_ready = 1'b1;
        step(a);
        check("release accepted", int'(a), 1);
        check("release median", int'(median), 0);
        check("release win_max", int'(win_max), 7);
        in_valid = 1'b0;

        // Clear mid-stream with in_valid high.
        clear = 1'b1; step(a); clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 2); step(a);
        end
        clear = 1'b1;
        step(a);
        check("clear fill", int'(fill), 0);
        clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_data = 4'(13 - i);
            step(a);
            check("post-clear out_valid", int'(out_valid), (i == 6) ? 1 : 0);
        end
        check("post-clear median", int'(median), 10);

        // Randomised traffic against the queue model.
        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 29) == 0);
            step(a);
            pending = in_valid && !a && !clear;
        end
        clear = 1'b0;

        // Reset while a result is being held.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 3); step(a);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        step(a);
        check("pre-rst out_valid", int'(out_valid), 1);
        rst = 1'b1;
        step(a);
        check("rst out_valid", int'(out_valid), 0);
        check("rst median", int'(median), 0);
        check("rst fill", int'(fill), 0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Signed compare, DEPTH=3.
        s_in_valid = 1'b1;
        s_in_data = 4'hF; @(posedge clk); #1;
        s_in_data = 4'h2; @(posedge clk); #1;
        check("signed warm-up out_valid", int'(s_out_valid), 0);
        check("signed fill", int'(s_fill), 2);
        s_in_data = 4'h8; @(posedge clk); #1;
        s_in_valid = 1'b0;
        check("signed out_valid", int'(s_out_valid), 1);
        check("signed median", int'(s_median), 15);
        check("signed win_min", int'(s_min), 8);
        check("signed win_max", int'(s_max), 2);
        check("signed in_ready", int'(s_in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
